port_arbiter: RTL

- Shares the single `ports` I/O block between NUM_REQ requesters, for example the CPU control path and a future DMA or debug master.
- Drives the `ports` inputs (portaddr, portval, portget, portset) and returns portout to the granted requester.
- Arbitration is round-robin; each transaction is a request/done handshake with a fixed, parameterised access time.
- Sits between the requesters and the `ports` instance in the top level.

---
 rtl/port_arbiter_pkg.sv | 21 ++
 rtl/port_arbiter_if.sv | 38 +++
 rtl/port_arbiter_rr_pick.sv | 41 ++++
 rtl/port_arbiter.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// port_arbiter_pkg
// Shared definitions for the port arbiter slice: default word width, the FSM
// state encoding, and a helper that sizes index/counter fields.
// -----------------------------------------------------------------------------
package port_arbiter_pkg;

    localparam int DEF_WORD_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACCESS   = 2'd1,
        ST_COMPLETE = 2'd2
    } state_t;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/port_arbiter_if.sv
// -----------------------------------------------------------------------------
// port_arbiter_if
// Requester-side bus of the port arbiter.
//   req        per-requester request level
//   req_write  per-requester direction (1 = write, 0 = read)
//   req_addr   flattened addresses, requester i at [i*WORD_WIDTH +: WORD_WIDTH]
//   req_wdata  flattened write data, same packing
//   gnt        one-hot grant, held for the whole transaction
//   done       one-hot, one-cycle completion pulse
//   rdata      read data, valid while done is high
//   busy       arbiter is not idle
// master: the requesters.  slave: the arbiter.
// -----------------------------------------------------------------------------
interface port_arbiter_if
    import port_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int WORD_WIDTH = DEF_WORD_WIDTH
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            req_write;
    logic [NUM_REQ*WORD_WIDTH-1:0] req_addr;
    logic [NUM_REQ*WORD_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            done;
    logic [WORD_WIDTH-1:0]         rdata;
    logic                          busy;

    modport master (
        output req, req_write, req_addr, req_wdata,
        input  gnt, done, rdata, busy
    );

    modport slave (
        input  req, req_write, req_addr, req_wdata,
        output gnt, done, rdata, busy
    );
endinterface

// File: rtl/port_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector.  Searches req starting at last+1 and
// wrapping, so the previous winner has the lowest priority.
//   req         request vector
//   last        index of the previous winner
//   win_onehot  one-hot winner (zero when no request)
//   win_idx     winner index
//   win_valid   at least one request present
// -----------------------------------------------------------------------------
module rr_pick
    import port_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] win_onehot,
    output logic [IDX_W-1:0]   win_idx,
    output logic               win_valid
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        win_onehot = '0;
        win_idx    = '0;
        win_valid  = 1'b0;
        cand       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(last) + k) % NUM_REQ);
            if (!win_valid && req[cand]) begin
                win_valid        = 1'b1;
                win_idx          = cand;
                win_onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/port_arbiter.sv
// -----------------------------------------------------------------------------
// port_arbiter
// Shares the single `ports` I/O block between NUM_REQ requesters with
// round-robin arbitration and a fixed ACCESS_CYCLES strobe time.
//   clk       system clock, rising edge
//   do_reset  asynchronous active-high reset
//   bus       requester handshake (slave side of port_arbiter_if)
//   portaddr  address to ports        portval  write value to ports
//   portget   read strobe to ports    portset  write strobe to ports
//   portout   read data from ports
// Every output comes straight from a register.
// -----------------------------------------------------------------------------
module port_arbiter
    import port_arbiter_pkg::*;
#(
    parameter int WORD_WIDTH    = DEF_WORD_WIDTH,
    parameter int NUM_REQ       = 4,    // 2..8
    parameter int ACCESS_CYCLES = 1     // >= 1
) (
    input  logic                  clk,
    input  logic                  do_reset,
    port_arbiter_if.slave         bus,
    output logic [WORD_WIDTH-1:0] portaddr,
    output logic [WORD_WIDTH-1:0] portval,
    output logic                  portget,
    output logic                  portset,
    input  logic [WORD_WIDTH-1:0] portout
);

    localparam int IDX_W = idx_width(NUM_REQ);
    localparam int CNT_W = idx_width(ACCESS_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(ACCESS_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_REQ - 1);

    state_t state, state_nxt;

    logic [CNT_W-1:0]      cnt,       cnt_nxt;
    logic [IDX_W-1:0]      last,      last_nxt;
    logic [IDX_W-1:0]      win_q,     win_nxt;
    logic [NUM_REQ-1:0]    gnt_q,     gnt_nxt;
    logic [NUM_REQ-1:0]    done_q,    done_nxt;
    logic [WORD_WIDTH-1:0] rdata_q,   rdata_nxt;
    logic                  busy_q,    busy_nxt;
    logic [WORD_WIDTH-1:0] paddr_q,   paddr_nxt;
    logic [WORD_WIDTH-1:0] pval_q,    pval_nxt;
    logic                  pget_q,    pget_nxt;
    logic                  pset_q,    pset_nxt;

    logic [NUM_REQ-1:0]    pick_onehot;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_valid;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req        (bus.req),
        .last       (last),
        .win_onehot (pick_onehot),
        .win_idx    (pick_idx),
        .win_valid  (pick_valid)
    );

    // State register
    always_ff @(posedge clk or posedge do_reset) begin
        if (do_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (pick_valid) state_nxt = ST_ACCESS;
            ST_ACCESS:   if (cnt == '0)  state_nxt = ST_COMPLETE;
            ST_COMPLETE: state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs and datapath
    always_comb begin
        cnt_nxt   = cnt;
        last_nxt  = last;
        win_nxt   = win_q;
        gnt_nxt   = gnt_q;
        done_nxt  = done_q;
        rdata_nxt = rdata_q;
        paddr_nxt = paddr_q;
        pval_nxt  = pval_q;
        pget_nxt  = pget_q;
        pset_nxt  = pset_q;
        busy_nxt  = (state_nxt != ST_IDLE);

        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    win_nxt   = pick_idx;
                    gnt_nxt   = pick_onehot;
                    paddr_nxt = bus.req_addr[int'(pick_idx)*WORD_WIDTH +: WORD_WIDTH];
                    pval_nxt  = bus.req_wdata[int'(pick_idx)*WORD_WIDTH +: WORD_WIDTH];
                    pset_nxt  = bus.req_write[pick_idx];
                    pget_nxt  = ~bus.req_write[pick_idx];
                    cnt_nxt   = CNT_LOAD;
                end
            end
            ST_ACCESS: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else begin
                    pget_nxt = 1'b0;
                    pset_nxt = 1'b0;
                    done_nxt = gnt_q;
                    last_nxt = win_q;
                    // The strobe is still high on this edge, so portout is
                    // the value ports is presenting for this read.
                    if (pget_q) rdata_nxt = portout;
                end
            end
            ST_COMPLETE: begin
                gnt_nxt  = '0;
                done_nxt = '0;
            end
            default: ;
        endcase
    end

    // Output and datapath registers; reset clears everything so an aborted
    // transaction leaves no grant, strobe, done or stale read data behind.
    always_ff @(posedge clk or posedge do_reset) begin
        if (do_reset) begin
            cnt     <= '0;
            last    <= LAST_INIT;
            win_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
            paddr_q <= '0;
            pval_q  <= '0;
            pget_q  <= 1'b0;
            pset_q  <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            last    <= last_nxt;
            win_q   <= win_nxt;
            gnt_q   <= gnt_nxt;
            done_q  <= done_nxt;
            rdata_q <= rdata_nxt;
            busy_q  <= busy_nxt;
            paddr_q <= paddr_nxt;
            pval_q  <= pval_nxt;
            pget_q  <= pget_nxt;
            pset_q  <= pset_nxt;
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.done  = done_q;
    assign bus.rdata = rdata_q;
    assign bus.busy  = busy_q;
    assign portaddr  = paddr_q;
    assign portval   = pval_q;
    assign portget   = pget_q;
    assign portset   = pset_q;

endmodule
